// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - shared types and constants for the fetch stage
// Provides XLEN, the canonical NOP encoding and the fetch FSM state type.
package fetch_ctrl_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_skid.sv
// rtl/fetch_skid.sv - 1-entry pc/instruction holding register
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   load_i            capture pc_i/instr_i and mark the entry valid
//   clear_i           drop the entry (wins over load_i)
//   pc_i, instr_i     entry to capture
//   valid_o, pc_o, instr_o  held entry
module fetch_skid
    import fetch_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            load_i,
    input  logic            clear_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] instr_i,
    output logic            valid_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] instr_o
);

    logic            valid_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] instr_q;

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
        end
        if (reset) begin
            pc_q    <= '0;
            instr_q <= '0;
        end else if (load_i && !clear_i) begin
            pc_q    <= pc_i;
            instr_q <= instr_i;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - fetch-stage sequencer: PC, imem drive, skid, redirects
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   stall                      decode cannot take the current if_* output
//   redirect_valid/_pc         taken branch/jump and its target
//   imem_en/imem_addr          read request to the 1-cycle-latency imem
//   imem_rdata                 imem data for the previous cycle's request
//   if_valid/if_pc/if_instr    instruction presented to IF/ID
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          IMEM_AW   = 9,
    parameter int          BOOT_WAIT = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               imem_en,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [XLEN-1:0]    imem_rdata,
    output logic               if_valid,
    output logic [XLEN-1:0]    if_pc,
    output logic [XLEN-1:0]    if_instr
);

    localparam int CW = $clog2(BOOT_WAIT + 2);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fa_q, fa_d;
    logic            rv_q, rv_d;
    logic [XLEN-1:0] rpc_q, rpc_d;
    logic [CW-1:0]   boot_cnt_q, boot_cnt_d;

    logic            skid_v, skid_load, skid_clear;
    logic [XLEN-1:0] skid_pc, skid_instr;
    logic            en_c;
    logic            hold;
    logic            active;
    logic [XLEN-1:0] rd_pc;

    assign rd_pc = redirect_pc & 32'hFFFF_FFFC;

    // Reset gates the outputs so stale state never leaks out while reset is held.
    assign if_valid = ~reset & ~redirect_valid & (skid_v | rv_q);
    assign if_pc    = if_valid ? (skid_v ? skid_pc    : rpc_q)      : '0;
    assign if_instr = if_valid ? (skid_v ? skid_instr : imem_rdata) : '0;
    assign hold     = stall & if_valid & ~redirect_valid;

    assign imem_en   = en_c & ~reset;
    assign imem_addr = redirect_valid ? rd_pc[IMEM_AW+1:2] : fa_q[IMEM_AW+1:2];

    // The last boot cycle already fetches, so BOOT_WAIT=0 fetches right after reset release.
    assign active = (state_q != BOOT) || (boot_cnt_q == CW'(BOOT_WAIT));

    always_comb begin
        state_d    = state_q;
        fa_d       = fa_q;
        rv_d       = rv_q;
        rpc_d      = rpc_q;
        boot_cnt_d = boot_cnt_q;
        en_c       = 1'b0;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        if (!active) begin
            boot_cnt_d = boot_cnt_q + CW'(1);
            if (redirect_valid) begin
                fa_d = rd_pc;
            end
        end else if (redirect_valid) begin
            en_c       = 1'b1;
            rpc_d      = rd_pc;
            rv_d       = 1'b1;
            fa_d       = rd_pc + 32'd4;
            skid_clear = 1'b1;
            state_d    = RUN;
        end else if (hold) begin
            // Entering HOLD parks the live output; while in HOLD the skid already has it.
            skid_load = (state_q != HOLD);
            rv_d      = 1'b0;
            state_d   = HOLD;
        end else begin
            // In HOLD this is the cycle decode accepts the skid entry.
            en_c       = 1'b1;
            rpc_d      = fa_q;
            rv_d       = 1'b1;
            fa_d       = fa_q + 32'd4;
            skid_clear = 1'b1;
            state_d    = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= BOOT;
            fa_q       <= RESET_PC;
            rv_q       <= 1'b0;
            rpc_q      <= '0;
            boot_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            fa_q       <= fa_d;
            rv_q       <= rv_d;
            rpc_q      <= rpc_d;
            boot_cnt_q <= boot_cnt_d;
        end
    end

    fetch_skid u_skid (
        .clk     (clk),
        .reset   (reset),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .pc_i    (rpc_q),
        .instr_i (imem_rdata),
        .valid_o (skid_v),
        .pc_o    (skid_pc),
        .instr_o (skid_instr)
    );

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed self-checking bench for fetch_ctrl
module tb_fetch_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1, stall = 1'b0, redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_en;
    logic [8:0]  imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        if_valid;
    logic [31:0] if_pc, if_instr;

    logic        reset_b = 1'b1, stall_b = 1'b0, redir_v_b = 1'b0;
    logic [31:0] redir_pc_b = '0;
    logic        en_b;
    logic [8:0]  addr_b;
    logic [31:0] rdata_b = '0;
    logic        valid_b;
    logic [31:0] pc_b, instr_b;

    int checks = 0;
    int errors = 0;

    fetch_ctrl #(.RESET_PC(32'h0000_0000), .IMEM_AW(9), .BOOT_WAIT(2)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr)
    );

    fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8), .IMEM_AW(9), .BOOT_WAIT(0)) dut_b (
        .clk(clk), .reset(reset_b), .stall(stall_b),
        .redirect_valid(redir_v_b), .redirect_pc(redir_pc_b),
        .imem_en(en_b), .imem_addr(addr_b), .imem_rdata(rdata_b),
        .if_valid(valid_b), .if_pc(pc_b), .if_instr(instr_b)
    );

    // imem model: word at address a holds 0x1357_0000 + a
    always @(posedge clk) if (imem_en) imem_rdata <= 32'h1357_0000 + {23'd0, imem_addr};
    always @(posedge clk) if (en_b)    rdata_b    <= 32'h1357_0000 + {23'd0, addr_b};

    function automatic logic [31:0] exp_instr(input logic [31:0] pc);
        return 32'h1357_0000 + ((pc >> 2) & 32'h1FF);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if (if_valid !== 1'b0 || imem_en !== 1'b0 || if_pc !== 32'd0 || if_instr !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b en=%b pc=%h instr=%h, want 0 0 0 0", if_valid, imem_en, if_pc, if_instr);
        end
        tick();
    endtask

    task automatic test_boot();
        logic       e_en [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic       e_v  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [31:0] e_pc[5] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd4};
        logic [8:0] e_ad [5] = '{9'd0, 9'd0, 9'd0, 9'd1, 9'd2};
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (imem_en !== e_en[c] || if_valid !== e_v[c] || if_pc !== e_pc[c]
                || (e_v[c] && if_instr !== exp_instr(e_pc[c]))
                || (e_en[c] && imem_addr !== e_ad[c])) begin
                errors++;
                $display("FAIL boot_c%0d: en=%b v=%b pc=%h instr=%h addr=%h, want en=%b v=%b pc=%h instr=%h addr=%h",
                         c, imem_en, if_valid, if_pc, if_instr, imem_addr,
                         e_en[c], e_v[c], e_pc[c], exp_instr(e_pc[c]), e_ad[c]);
            end
            tick();
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (if_valid !== 1'b1 || if_pc !== 32'd8 || if_instr !== exp_instr(32'd8) || imem_en !== 1'b0) begin
                errors++;
                $display("FAIL stall_c%0d: v=%b pc=%h instr=%h en=%b, want 1 00000008 %h 0",
                         c, if_valid, if_pc, if_instr, imem_en, exp_instr(32'd8));
            end
            tick();
        end
        stall = 1'b0;
        @(negedge clk);
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'd8 || imem_en !== 1'b1 || imem_addr !== 9'd3) begin
            errors++;
            $display("FAIL stall_release: v=%b pc=%h en=%b addr=%h, want 1 00000008 1 003", if_valid, if_pc, imem_en, imem_addr);
        end
        tick();
        @(negedge clk);
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'd12 || if_instr !== exp_instr(32'd12)) begin
            errors++;
            $display("FAIL stall_next: v=%b pc=%h instr=%h, want 1 0000000c %h", if_valid, if_pc, if_instr, exp_instr(32'd12));
        end
        tick();
    endtask

    task automatic test_redirect();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        @(negedge clk);
        checks++;
        if (if_valid !== 1'b0 || imem_en !== 1'b1 || imem_addr !== 9'h40) begin
            errors++;
            $display("FAIL redirect_cycle: v=%b en=%b addr=%h, want 0 1 040", if_valid, imem_en, imem_addr);
        end
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_instr !== exp_instr(32'h100) || imem_addr !== 9'h41) begin
            errors++;
            $display("FAIL redirect_target: v=%b pc=%h instr=%h addr=%h, want 1 00000100 %h 041",
                     if_valid, if_pc, if_instr, imem_addr, exp_instr(32'h100));
        end
        tick();
    endtask

    task automatic test_hold_redirect();
        stall = 1'b1;
        @(negedge clk);
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h104 || imem_en !== 1'b0) begin
            errors++;
            $display("FAIL hold_enter: v=%b pc=%h en=%b, want 1 00000104 0", if_valid, if_pc, imem_en);
        end
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        @(negedge clk);
        checks++;
        if (if_valid !== 1'b0 || imem_en !== 1'b1 || imem_addr !== 9'h80) begin
            errors++;
            $display("FAIL hold_redirect: v=%b en=%b addr=%h, want 0 1 080", if_valid, imem_en, imem_addr);
        end
        tick();
        redirect_valid = 1'b0;
        stall          = 1'b0;
        @(negedge clk);
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h200 || if_instr !== exp_instr(32'h200)) begin
            errors++;
            $display("FAIL hold_redirect_target: v=%b pc=%h instr=%h, want 1 00000200 %h", if_valid, if_pc, if_instr, exp_instr(32'h200));
        end
        tick();
    endtask

    task automatic test_reset_in_hold();
        stall = 1'b1;
        @(negedge clk);
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h204 || imem_en !== 1'b0) begin
            errors++;
            $display("FAIL rih_hold: v=%b pc=%h en=%b, want 1 00000204 0", if_valid, if_pc, imem_en);
        end
        tick();
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (if_valid !== 1'b0 || imem_en !== 1'b0) begin
            errors++;
            $display("FAIL rih_during_reset: v=%b en=%b, want 0 0", if_valid, imem_en);
        end
        tick();
        reset = 1'b0;
        // stall stays high: with if_valid=0 it must not block the first fetch
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (if_valid !== 1'b0 || imem_en !== (c == 2) || (c == 2 && imem_addr !== 9'd0)) begin
                errors++;
                $display("FAIL rih_boot_c%0d: v=%b en=%b addr=%h, want v=0 en=%b addr=000", c, if_valid, imem_en, imem_addr, (c == 2));
            end
            tick();
        end
        stall = 1'b0;
        @(negedge clk);
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'd0 || if_instr !== exp_instr(32'd0)) begin
            errors++;
            $display("FAIL rih_first: v=%b pc=%h instr=%h, want 1 00000000 %h", if_valid, if_pc, if_instr, exp_instr(32'd0));
        end
        tick();
    endtask

    task automatic test_back_to_back();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        @(negedge clk);
        checks++;
        if (if_valid !== 1'b0 || imem_en !== 1'b1 || imem_addr !== 9'hC0) begin
            errors++;
            $display("FAIL b2b_first: v=%b en=%b addr=%h, want 0 1 0c0", if_valid, imem_en, imem_addr);
        end
        tick();
        // low bits dropped, upper bits outside imem range kept in the PC
        redirect_pc = 32'h8000_0802;
        @(negedge clk);
        checks++;
        if (if_valid !== 1'b0 || imem_en !== 1'b1 || imem_addr !== 9'h000) begin
            errors++;
            $display("FAIL b2b_second: v=%b en=%b addr=%h, want 0 1 000", if_valid, imem_en, imem_addr);
        end
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h8000_0800 || if_instr !== 32'h1357_0000 || imem_addr !== 9'd1) begin
            errors++;
            $display("FAIL b2b_target: v=%b pc=%h instr=%h addr=%h, want 1 80000800 13570000 001", if_valid, if_pc, if_instr, imem_addr);
        end
        tick();
        @(negedge clk);
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h8000_0804 || if_instr !== 32'h1357_0001) begin
            errors++;
            $display("FAIL b2b_next: v=%b pc=%h instr=%h, want 1 80000804 13570001", if_valid, if_pc, if_instr);
        end
        tick();
    endtask

    task automatic test_wrap();
        logic [31:0] e_pc [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        logic [31:0] e_in [3] = '{32'h1357_01FE, 32'h1357_01FF, 32'h1357_0000};
        logic [8:0]  e_ad [3] = '{9'h1FF, 9'h000, 9'h001};
        reset_b = 1'b0;
        @(negedge clk);
        checks++;
        if (valid_b !== 1'b0 || en_b !== 1'b1 || addr_b !== 9'h1FE) begin
            errors++;
            $display("FAIL wrap_first_fetch: v=%b en=%b addr=%h, want 0 1 1fe", valid_b, en_b, addr_b);
        end
        tick();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (valid_b !== 1'b1 || pc_b !== e_pc[c] || instr_b !== e_in[c] || addr_b !== e_ad[c]) begin
                errors++;
                $display("FAIL wrap_c%0d: v=%b pc=%h instr=%h addr=%h, want 1 %h %h %h",
                         c, valid_b, pc_b, instr_b, addr_b, e_pc[c], e_in[c], e_ad[c]);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_boot();
        test_stall();
        test_redirect();
        test_hold_redirect();
        test_reset_in_hold();
        test_back_to_back();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
